// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: single-entry sample buffer feeding a free-running I2S serializer.
// Optional macro I2S_TX_VOLUME_EN adds an arithmetic-shift attenuator at frame load.
module i2s_audio_tx #(
  parameter int BCK_HALF = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_stb,
  input  logic [15:0] left,
  input  logic [15:0] right,
  input  logic [2:0]  vol,
  input  logic        clr_status,
  output logic        overrun,
  output logic        underrun,
  output logic        audio_bck,
  output logic        audio_lrck,
  output logic        audio_data
);

  localparam int DW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BCK_HALF - 1);

  logic [DW-1:0] div_q, div_d;
  logic          bck_q, bck_d;
  logic          lrck_q, lrck_d;
  logic          data_q, data_d;
  logic [4:0]    slot_q, slot_d;
  logic [31:0]   sr_q, sr_d;
  logic [15:0]   hold_l_q, hold_l_d;
  logic [15:0]   hold_r_q, hold_r_d;
  logic          fresh_q, fresh_d;
  logic          ovr_q, ovr_d;
  logic          und_q, und_d;

  logic          wrap;
  logic          fall;
  logic          load;
  logic [15:0]   l_proc;
  logic [15:0]   r_proc;
  logic [31:0]   word;

  assign wrap = (div_q == DIV_MAX);
  assign fall = wrap & bck_q;
  assign load = fall & (slot_q == 5'd0);

`ifdef I2S_TX_VOLUME_EN
  assign l_proc = $signed(hold_l_q) >>> vol;
  assign r_proc = $signed(hold_r_q) >>> vol;
`else
  logic unused_vol;
  assign unused_vol = ^vol;
  assign l_proc = hold_l_q;
  assign r_proc = hold_r_q;
`endif

  assign word = {l_proc, r_proc};

  // Next-state: bit-clock divider, slot sequencing, serializer, buffer and flags
  always_comb begin
    div_d    = wrap ? '0 : div_q + 1'b1;
    bck_d    = wrap ? ~bck_q : bck_q;
    slot_d   = slot_q;
    lrck_d   = lrck_q;
    data_d   = data_q;
    sr_d     = sr_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    fresh_d  = fresh_q;
    ovr_d    = ovr_q & ~clr_status;
    und_d    = und_q & ~clr_status;

    if (fall) begin
      slot_d = slot_q + 5'd1;
      lrck_d = slot_d[4];
      if (load) begin
        sr_d   = word;
        data_d = word[31];
      end else begin
        sr_d   = {sr_q[30:0], 1'b0};
        data_d = sr_q[30];
      end
    end

    if (load) begin
      fresh_d = 1'b0;
      if (!fresh_q) und_d = 1'b1;
    end

    if (sample_stb) begin
      hold_l_d = left;
      hold_r_d = right;
      fresh_d  = 1'b1;
      if (fresh_q && !load) ovr_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      bck_q    <= 1'b0;
      lrck_q   <= 1'b0;
      data_q   <= 1'b0;
      slot_q   <= '0;
      sr_q     <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      fresh_q  <= 1'b0;
      ovr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bck_q    <= bck_d;
      lrck_q   <= lrck_d;
      data_q   <= data_d;
      slot_q   <= slot_d;
      sr_q     <= sr_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      fresh_q  <= fresh_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  assign audio_bck  = bck_q;
  assign audio_lrck = lrck_q;
  assign audio_data = data_q;
  assign overrun    = ovr_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: directed stimulus with a slot-by-slot scoreboard
// for i2s_audio_tx at BCK_HALF=13 (832 clk per frame).
module tb_i2s_audio_tx;

  localparam int BCK_HALF = 13;

`ifdef I2S_TX_VOLUME_EN
  localparam logic [31:0] VOL_WORD = 32'hF000_0008;
`else
  localparam logic [31:0] VOL_WORD = 32'h8000_0040;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_stb = 1'b0;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  logic [2:0]  vol = '0;
  logic        clr_status = 1'b0;
  logic        overrun;
  logic        underrun;
  logic        audio_bck;
  logic        audio_lrck;
  logic        audio_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int frame;
    int slot;
    bit lrck;
    bit data;
  } exp_t;

  exp_t sb[$];

  int m_slot = 0;
  int m_frame = 0;
  bit prev_bck = 1'b0;

  i2s_audio_tx #(.BCK_HALF(BCK_HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_stb (sample_stb),
    .left       (left),
    .right      (right),
    .vol        (vol),
    .clr_status (clr_status),
    .overrun    (overrun),
    .underrun   (underrun),
    .audio_bck  (audio_bck),
    .audio_lrck (audio_lrck),
    .audio_data (audio_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h",
               name, cyc, act, exp);
    end
  endtask

  // Monitor: on every bck fall a new slot is entered; compare lrck/data
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_bck = 1'b0;
      m_slot = 0;
      m_frame = 0;
    end else begin
      if (prev_bck && !audio_bck) begin
        m_slot = (m_slot + 1) % 32;
        if (m_slot == 1) m_frame++;
        if (sb.size() > 0 && sb[0].frame == m_frame
            && sb[0].slot == m_slot) begin
          e = sb.pop_front();
          check($sformatf("frame%0d slot%0d {lrck,data}", m_frame, m_slot),
                {30'd0, audio_lrck, audio_data},
                {30'd0, e.lrck, e.data});
        end
      end
      prev_bck = audio_bck;
    end
  end

  task automatic push_frame(input int f, input logic [31:0] w, input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.frame = f;
      e.slot = k % 32;
      e.lrck = (e.slot >= 16);
      e.data = w[32-k];
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] l, input logic [15:0] r);
    sample_stb = 1'b1;
    left = l;
    right = r;
    @(negedge clk);
    sample_stb = 1'b0;
  endtask

  task automatic clear_flags();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic first_frame();
    check("rst bck", {31'd0, audio_bck}, 32'd0);
    check("rst lrck", {31'd0, audio_lrck}, 32'd0);
    check("rst data", {31'd0, audio_data}, 32'd0);
    check("rst overrun", {31'd0, overrun}, 32'd0);
    check("rst underrun", {31'd0, underrun}, 32'd0);
    push_frame(1, 32'h0, 32);
    wait_cyc(12);
    check("bck before rise", {31'd0, audio_bck}, 32'd0);
    wait_cyc(13);
    check("bck first rise", {31'd0, audio_bck}, 32'd1);
    wait_cyc(25);
    check("bck before fall", {31'd0, audio_bck}, 32'd1);
    check("underrun before load", {31'd0, underrun}, 32'd0);
    wait_cyc(26);
    check("bck first fall", {31'd0, audio_bck}, 32'd0);
    wait_cyc(27);
    check("underrun after empty load", {31'd0, underrun}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    first_frame();

    wait_cyc(100);
    clear_flags();
    check("underrun cleared", {31'd0, underrun}, 32'd0);
    wait_cyc(200);
    push_frame(2, 32'h8001_7FFE, 32);
    pulse(16'h8001, 16'h7FFE);
    check("no overrun single stb", {31'd0, overrun}, 32'd0);
    wait_cyc(859);
    check("frame2 underrun", {31'd0, underrun}, 32'd0);
    check("frame2 overrun", {31'd0, overrun}, 32'd0);

    wait_cyc(1000);
    pulse(16'h1234, 16'h5678);
    check("overrun after first stb", {31'd0, overrun}, 32'd0);
    wait_cyc(1005);
    push_frame(3, 32'hA5A5_0F0F, 32);
    pulse(16'hA5A5, 16'h0F0F);
    check("overrun after second stb", {31'd0, overrun}, 32'd1);
    wait_cyc(1100);
    check("overrun sticky", {31'd0, overrun}, 32'd1);
    clear_flags();
    check("overrun cleared", {31'd0, overrun}, 32'd0);
    wait_cyc(1691);
    check("frame3 underrun", {31'd0, underrun}, 32'd0);

    wait_cyc(1800);
    push_frame(4, 32'h1111_2222, 32);
    pulse(16'h1111, 16'h2222);
    wait_cyc(2521);
    push_frame(5, 32'hC3C3_3C3C, 32);
    pulse(16'hC3C3, 16'h3C3C);
    #1;
    check("stb at load overrun", {31'd0, overrun}, 32'd0);
    check("stb at load underrun", {31'd0, underrun}, 32'd0);
    wait_cyc(3355);
    check("frame5 underrun", {31'd0, underrun}, 32'd0);
    check("frame5 overrun", {31'd0, overrun}, 32'd0);

    wait_cyc(3500);
    vol = 3'd3;
    push_frame(6, VOL_WORD, 32);
    pulse(16'h8000, 16'h0040);
    wait_cyc(4187);
    check("frame6 underrun", {31'd0, underrun}, 32'd0);
    vol = 3'd0;

    wait_cyc(4300);
    push_frame(7, 32'h00FF_FFFF, 9);
    pulse(16'h00FF, 16'hFFFF);
    wait_cyc(4305);
    pulse(16'h00FF, 16'hFFFF);
    check("frame7 overrun", {31'd0, overrun}, 32'd1);
    wait_cyc(5245);
    check("slot9 bck", {31'd0, audio_bck}, 32'd1);
    check("slot9 data", {31'd0, audio_data}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst bck", {31'd0, audio_bck}, 32'd0);
    check("async rst data", {31'd0, audio_data}, 32'd0);
    check("async rst lrck", {31'd0, audio_lrck}, 32'd0);
    check("async rst overrun", {31'd0, overrun}, 32'd0);
    check("async rst underrun", {31'd0, underrun}, 32'd0);
    check("frame7 entries seen", sb.size(), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    first_frame();
    wait_cyc(862);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
